// File: rtl/ram_req_queue.sv
// ram_req_queue
//   In-order request queue and sequencer sitting directly in front of a
//   single-ported ram64. Requests {we, addr, data} are accepted over a
//   valid/ready handshake into a DEPTH-entry FIFO. The FIFO head is presented
//   combinationally to the RAM port, and at most one request issues per cycle.
//   Read data is captured into a registered valid/ready response channel.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake; req_ready = !full
//   req_we/req_addr/req_data   request payload (data ignored for reads)
//   rsp_valid/rsp_ready        read response handshake
//   rsp_data                   registered read data
//   ram_in/ram_addr/ram_load   drive ram64 (load = write strobe)
//   ram_out                    ram64 read data, combinational on ram_addr
//
// Optional build macro
//   RAM_REQ_QUEUE_STATS_EN : adds saturating 16-bit counters stat_wr, stat_rd
//                            (issued writes / reads) and stat_stall (cycles
//                            with req_valid && !req_ready).

module ram_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [DW-1:0] ram_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_load,
  input  logic [DW-1:0] ram_out
`ifdef RAM_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          fifo_we   [DEPTH];
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic empty;
  logic head_we;
  logic push;
  logic pop;
  logic rd_issue;

  // Fullness is judged on the registered count only, so a pop in the same
  // cycle does not open a slot until the following cycle.
  assign empty     = (count == '0);
  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head_we   = fifo_we[rptr];

  // Writes never depend on the response channel; a read may only issue when
  // its result has somewhere to go (slot empty or being drained this cycle).
  assign pop      = !empty && (head_we || !rsp_valid || rsp_ready);
  assign rd_issue = pop && !head_we;

  always_comb begin
    ram_addr = '0;
    ram_in   = '0;
    if (!empty) begin
      ram_addr = fifo_addr[rptr];
      ram_in   = fifo_data[rptr];
    end
  end

  assign ram_load = pop && head_we;

  // Payload storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wptr]   <= req_we;
      fifo_addr[wptr] <= req_addr;
      fifo_data[wptr] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (rd_issue) begin
      rsp_valid <= 1'b1;
      rsp_data  <= ram_out;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef RAM_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr    <= '0;
      stat_rd    <= '0;
      stat_stall <= '0;
    end else begin
      if (ram_load && (stat_wr != '1))                 stat_wr    <= stat_wr + 16'd1;
      if (rd_issue && (stat_rd != '1))                 stat_rd    <= stat_rd + 16'd1;
      if (req_valid && !req_ready && (stat_stall != '1)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
